// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the bit-serial adder: FSM state encoding and the
//   helper that sizes the bit counter for a given operand width.
// -----------------------------------------------------------------------------
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter width able to hold 0..width; a width of at least 1 is always returned.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width < 1) ? 1 : $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
//   Operand/result handshake bundle for serial_adder.
//   in_valid/in_ready : operand transfer (a, b, cin)
//   out_valid/out_ready : result transfer (sum, cout)
//   busy : adder is in RUN or DONE
//   master : operand source / result consumer side
//   slave  : adder side
// -----------------------------------------------------------------------------
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

// File: rtl/fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//   Combinational 1-bit full adder.
//   a, b, cin : input bits
//   s         : sum bit
//   co        : carry-out bit
// -----------------------------------------------------------------------------
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands are accepted in IDLE, added LSB-first
//   one bit per clock through a single fa_cell and a carry flop (RUN, exactly
//   WIDTH cycles), and the result is offered in DONE until taken.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_if slave (operand/result handshakes, busy)
// -----------------------------------------------------------------------------
module serial_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);

   localparam int unsigned   CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fa_s, fa_co;

   fa_cell u_fa (
      .a   (a_q[0]),
      .b   (b_q[0]),
      .cin (carry_q),
      .s   (fa_s),
      .co  (fa_co)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sh_d    = sh_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Shift written as shift-then-insert so WIDTH=1 needs no empty slice.
            sh_d            = sh_q >> 1;
            sh_d[WIDTH-1]   = fa_s;
            a_d             = a_q >> 1;
            b_d             = b_q >> 1;
            carry_d         = fa_co;
            if (cnt_q == LAST) begin
               // Output registers load only here, so they hold the previous
               // result through IDLE and RUN.
               sum_d   = sh_d;
               cout_d  = fa_co;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sh_q    <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sh_q    <= sh_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;

endmodule
